// File: rtl/multibit_handshake_pkg.sv
// Shared types and sizes for the toggle-handshake receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package multibit_handshake_pkg;

    // Receiver condition: nothing outstanding, or a word waiting for buffer space
    typedef enum logic [0:0] {
        IDLE       = 1'b0,
        WAIT_SPACE = 1'b1
    } hs_rx_state_t;

    localparam int RX_BUF_DEPTH = 2;
    localparam int RX_COUNT_W   = 16;

endpackage

// File: rtl/multibit_handshake_sync.sv
// N-stage single-bit synchronizer for a level or toggle crossing into i_clk.
// Latency: output follows input after STAGES rising edges.
// Backpressure: none; samples every cycle.
module multibit_handshake_sync #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    // Shift the asynchronous input through the flop chain
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/multibit_handshake_rx.sv
// Receive side of a two-phase bundled-data handshake, buffering words in a 2-entry queue.
// Latency: capture and ack toggle on edge SYNC_STAGES+1 after a req toggle; bvalid follows the same edge.
// Backpressure: with both entries full the ack toggle is withheld, stalling the transmitter without loss.
module multibit_handshake_rx
    import multibit_handshake_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req,
    input  logic [DATA_WIDTH-1:0] rx_data,
    output logic                  ack,
    output logic                  bvalid,
    output logic [DATA_WIDTH-1:0] bdata,
    input  logic                  bready,
    output logic [RX_COUNT_W-1:0] rx_count
);

    localparam logic [1:0] LP_DEPTH = 2'(RX_BUF_DEPTH);

    logic                  w_req_s;
    logic                  w_pending;
    logic                  w_space;
    logic                  w_push;
    logic                  w_pop;
    hs_rx_state_t          r_state;
    hs_rx_state_t          w_state_nxt;
    logic                  r_ack;
    logic [1:0]            r_count;
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_mem [RX_BUF_DEPTH];
    logic [RX_COUNT_W-1:0] r_rx_count;

    multibit_handshake_sync #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_d     (req),
        .o_q     (w_req_s)
    );

    // A word is outstanding while the synchronized req differs from our ack
    assign w_pending = w_req_s ^ r_ack;
    assign w_space   = (r_count < LP_DEPTH);
    assign w_pop     = bvalid && bready;

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and capture strobe; a full buffer holds off the capture
    always_comb begin
        w_state_nxt = r_state;
        w_push      = w_pending && w_space;
        case (r_state)
            IDLE: begin
                if (w_pending && !w_space) begin
                    w_state_nxt = WAIT_SPACE;
                end
            end
            WAIT_SPACE: begin
                if (!(w_pending && !w_space)) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Capture: write tail, flip ack, bump the lifetime word counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ack      <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_rx_count <= '0;
            for (int i = 0; i < RX_BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_ack             <= ~r_ack;
            r_wr_ptr          <= ~r_wr_ptr;
            r_rx_count        <= r_rx_count + 1'b1;
            r_mem[r_wr_ptr]   <= rx_data;
        end
    end

    // Occupancy and head pointer; push is never taken when full, so no overflow case
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count  <= 2'd0;
            r_rd_ptr <= 1'b0;
        end else begin
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign ack      = r_ack;
    assign bvalid   = (r_count != 2'd0);
    assign bdata    = r_mem[r_rd_ptr];
    assign rx_count = r_rx_count;

endmodule

// File: doc/multibit_handshake_rx.md
# multibit_handshake_rx

Receiving end of a two-phase (toggle) bundled-data handshake used to move multi-bit words into a single clock domain. The transmitter flips `req` after placing a word on `rx_data`. This block synchronizes `req`, captures the word, and flips `ack` back to the transmitter. Captured words are buffered in a 2-entry FIFO and presented downstream on a valid/ready interface.

## Interface
- `DATA_WIDTH`, default 32, width of the transferred word.
- `SYNC_STAGES`, default 2, flops in the `req` synchronizer; legal range ≥2.
- `clk` in 1: the single clock of the block.
- `reset_n` in 1: asynchronous, active-low reset. All flops clear on assertion. Release is synchronous to `clk`, handled externally.
- `req` in 1: toggle from the transmitter, asynchronous to `clk`. Each level change means one new word.
- `rx_data` in DATA_WIDTH: bundled data. The transmitter holds it stable from before its `req` toggle until it observes the matching `ack` toggle.
- `ack` out 1: registered toggle back to the transmitter. Flips once per captured word.
- `bvalid` out 1: buffer holds at least one word.
- `bdata` out DATA_WIDTH: head word of the buffer. Valid only while `bvalid` is high.
- `bready` in 1: downstream accepts `bdata` on an edge where `bvalid` and `bready` are both high.
- `rx_count` out 16: count of captured words, wraps modulo 2^16.

## Operation
- `req` passes through SYNC_STAGES flops, each resetting to 0, to produce `req_s`.
- `pending = req_s ^ ack`. `space = (count < 2)`. There is no same-cycle push-while-full pass-through.
- Two FSM states:
  - IDLE: `pending` is 0.
  - WAIT_SPACE: `pending` is 1 and `space` is 0.
- On any edge where `pending` is high and `space` is high:
  - write `rx_data` to the tail entry;
  - toggle `ack`;
  - increment `count` and `rx_count`.
- `ack` is a flop output. `pending` falls on the edge after capture, so there is exactly one capture per `req` toggle.
- Pop: on an edge with `bvalid && bready`, advance the head and decrement `count`.
- Push and pop on the same edge with `count` = 1 leaves `count` = 1. The new word becomes head on the next cycle.
- Same edge with `count` = 2: pop only. The push waits for the next edge.
- `bvalid = (count != 0)`. `bdata` is read from the registered storage at the head pointer.
- Pointers are 1 bit wide and wrap 1→0. `count` is 2 bits wide, range 0..2.
- Reset values:
  - `ack` = 0, `bvalid` = 0, `bdata` = 0 (storage cleared), `rx_count` = 0;
  - pointers = 0, sync flops = 0, FSM = IDLE.
- Reset mid-transfer drops any buffered and in-flight words. The transmitter end must be reset in the same reset domain event.
- If `req` is 1 when reset releases, that is treated as one pending word and captured normally.

## Timing
- Latency, `req` toggle to capture: `req` changes before edge 1, `req_s` reflects it after edge SYNC_STAGES, and capture plus the `ack` toggle happen at edge SYNC_STAGES+1.
- `bvalid` rises after edge SYNC_STAGES+1 when the buffer was empty. That is edge 3 for the default.
- Downstream stall: when `count` = 2, `ack` is withheld. This backpressures the transmitter with no data loss.
- Once a slot frees, capture occurs on the following edge.
- `bvalid` never drops without a pop. `bdata` does not change while `bvalid && !bready`.
- There is no combinational path from `bready`, `req`, or `rx_data` to any output.

## Structure
- Shared package `multibit_handshake_pkg` holds:
  - FSM state typedef `hs_rx_state_t` (IDLE, WAIT_SPACE);
  - `RX_BUF_DEPTH = 2`;
  - `RX_COUNT_W = 16`.
- One sub-module, `multibit_handshake_sync`: an N-stage single-bit synchronizer with async active-low reset, parameter STAGES. It is instantiated once for `req`.

## Test plan
- Reset, then a single transfer: `rx_data`=0xDEADBEEF and toggle `req` 0→1. Expect `ack` 0→1 and `bvalid`=1 with `bdata`=0xDEADBEEF, both at edge 3. `rx_count`=1.
- Back-to-back: the transmitter model sends 0x1, 0x2, 0x3, waiting for each `ack` toggle, with `bready`=1. Expect `bdata` sequence 1, 2, 3 with no duplicates. `rx_count`=3.
- Backpressure: hold `bready`=0 and send 0xA, 0xB, 0xC. Expect two `ack` toggles, the third withheld, FSM = WAIT_SPACE, and `bdata` held at 0xA. Then raise `bready`: expect the third capture one edge after the first pop, and output order A, B, C.
- Simultaneous push and pop at `count`=1: expect `count` to stay 1, `bvalid` to stay 1, and the next `bdata` to be the newly captured word.
- Assert `reset_n` while `count`=2 and `req` is pending. Expect immediate `bvalid`=0, `ack`=0, `bdata`=0, `rx_count`=0. With `req` held 1 through release, expect exactly one capture after SYNC_STAGES+1 edges.
- Re-run the single-transfer scenario with SYNC_STAGES=3 and check capture at edge 4.
